// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite renderers: FSM state encoding and a width helper.
// Also intended for the future multi-sprite mux.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    FETCH_SETUP,
    FETCH_CAPTURE,
    WAIT_HSTART,
    DRAW
  } state_t;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sprite_row_fetcher.sv
// Fills the sprite row buffer from the byte-wide bitmap ROM, one address/capture pair per byte.
// The owning FSM drives start (clear byte index), setup (issue address) and capture (latch data).
module sprite_row_fetcher
  import sprite_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 16,
  localparam int BPR = W / 8,
  localparam int AW = clog2(H * BPR),
  localparam int YW = clog2(H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          setup,
  input  logic          capture,
  input  logic [YW-1:0] row,
  input  logic [7:0]    rom_bits,
  output logic [AW-1:0] rom_addr,
  output logic [W-1:0]  rowbuf,
  output logic          ready
);

  localparam int BW = clog2(BPR);

  logic [BW-1:0] byte_idx;

  // The byte index only wraps through start, so it parks on the last byte until the next row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      rom_addr <= '0;
      rowbuf   <= '0;
    end else begin
      if (start) begin
        byte_idx <= '0;
      end else if (capture && (byte_idx != BW'(BPR - 1))) begin
        byte_idx <= byte_idx + 1'b1;
      end
      if (setup) begin
        rom_addr <= {row, byte_idx};
      end
      if (capture) begin
        rowbuf[8*byte_idx +: 8] <= rom_bits;
      end
    end
  end

  assign ready = capture && (byte_idx == BW'(BPR - 1));

endmodule

// File: rtl/sprite_renderer_gen.sv
// Scanline sprite renderer: W x H 1bpp bitmap with h/v mirroring, row fetched during hblank.
// Define SPRITE_RENDERER_SCALE2_EN to add the scale2 port for 2x pixel/line doubling.
module sprite_renderer_gen
  import sprite_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 16,
  localparam int BPR = W / 8,
  localparam int AW = clog2(H * BPR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vstart,
  input  logic          load,
  input  logic          hstart,
  input  logic          hmirror,
  input  logic          vmirror,
`ifdef SPRITE_RENDERER_SCALE2_EN
  input  logic          scale2,
`endif
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_bits,
  output logic          gfx,
  output logic          busy,
  output logic          done
);

  localparam int XW = clog2(W);
  localparam int YW = clog2(H);

  state_t        state;
  state_t        next_state;
  logic [XW-1:0] xcount;
  logic [YW-1:0] ycount;
  logic [W-1:0]  rowbuf;
  logic [YW-1:0] fetch_row;
  logic [XW-1:0] pix_idx;
  logic          fetch_start;
  logic          fetch_setup;
  logic          fetch_capture;
  logic          fetch_ready;
  logic          x_step;
  logic          line_end;
  logic          row_end;
  logic          frame_end;
  logic          skip_fetch;

  assign fetch_row = vmirror ? (YW'(H - 1) - ycount) : ycount;
  assign pix_idx   = hmirror ? (XW'(W - 1) - xcount) : xcount;
  assign line_end  = (state == DRAW) && (xcount == XW'(W - 1)) && x_step;
  assign frame_end = row_end && (ycount == YW'(H - 1));

`ifdef SPRITE_RENDERER_SCALE2_EN
  logic scale_q;
  logic half;
  logic line_dup;

  // half holds each pixel for two clocks; line_dup marks the repeat line that reuses rowbuf.
  assign x_step     = !scale_q || half;
  assign row_end    = line_end && (!scale_q || line_dup);
  assign skip_fetch = scale_q && line_dup;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scale_q  <= 1'b0;
      half     <= 1'b0;
      line_dup <= 1'b0;
    end else begin
      if (state == IDLE) begin
        line_dup <= 1'b0;
        if (vstart) begin
          scale_q <= scale2;
        end
      end else if (line_end && scale_q) begin
        line_dup <= !line_dup;
      end
      if (state == WAIT_LOAD) begin
        half <= 1'b0;
      end else if ((state == DRAW) && scale_q) begin
        half <= !half;
      end
    end
  end
`else
  assign x_step     = 1'b1;
  assign row_end    = line_end;
  assign skip_fetch = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:          if (vstart) next_state = WAIT_LOAD;
      WAIT_LOAD:     if (load) next_state = skip_fetch ? WAIT_HSTART : FETCH_SETUP;
      FETCH_SETUP:   next_state = FETCH_CAPTURE;
      FETCH_CAPTURE: next_state = fetch_ready ? WAIT_HSTART : FETCH_SETUP;
      WAIT_HSTART:   if (hstart) next_state = DRAW;
      DRAW:          if (line_end) next_state = frame_end ? IDLE : WAIT_LOAD;
      default:       next_state = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != IDLE);
    fetch_start   = (state == WAIT_LOAD);
    fetch_setup   = (state == FETCH_SETUP);
    fetch_capture = (state == FETCH_CAPTURE);
  end

  // gfx is forced low outside DRAW so the line edges are clean without a separate blank signal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xcount <= '0;
      ycount <= '0;
      gfx    <= 1'b0;
      done   <= 1'b0;
    end else begin
      gfx  <= (state == DRAW) ? rowbuf[pix_idx] : 1'b0;
      done <= frame_end;
      if (state == IDLE) begin
        ycount <= '0;
      end else if (row_end) begin
        ycount <= ycount + 1'b1;
      end
      if (state == WAIT_LOAD) begin
        xcount <= '0;
      end else if ((state == DRAW) && x_step) begin
        xcount <= xcount + 1'b1;
      end
    end
  end

  sprite_row_fetcher #(
    .W(W),
    .H(H)
  ) u_fetcher (
    .clk      (clk),
    .reset    (reset),
    .start    (fetch_start),
    .setup    (fetch_setup),
    .capture  (fetch_capture),
    .row      (fetch_row),
    .rom_bits (rom_bits),
    .rom_addr (rom_addr),
    .rowbuf   (rowbuf),
    .ready    (fetch_ready)
  );

endmodule

// File: tb/tb_sprite_renderer_gen.sv
// Randomized bench for sprite_renderer_gen: a 16x16 and a 32x8 instance run frames side by side
// against a pixel-level model of ROM row, mirroring and hstart latency.
module tb_sprite_renderer_gen;

  logic       clk;
  logic       reset;
  logic       vstart;
  logic       load;
  logic       hstart;
  logic       hmirror;
  logic       vmirror;
  logic [4:0] rom_addr_a;
  logic [4:0] rom_addr_b;
  logic [7:0] rom_bits_a;
  logic [7:0] rom_bits_b;
  logic       gfx_a, busy_a, done_a;
  logic       gfx_b, busy_b, done_b;

  logic [7:0] rom_a [32];
  logic [7:0] rom_b [32];

  int check_count;
  int pass_count;

  assign rom_bits_a = rom_a[rom_addr_a];
  assign rom_bits_b = rom_b[rom_addr_b];

  sprite_renderer_gen #(.W(16), .H(16)) u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .vstart   (vstart),
    .load     (load),
    .hstart   (hstart),
    .hmirror  (hmirror),
    .vmirror  (vmirror),
    .rom_addr (rom_addr_a),
    .rom_bits (rom_bits_a),
    .gfx      (gfx_a),
    .busy     (busy_a),
    .done     (done_a)
  );

  sprite_renderer_gen #(.W(32), .H(8)) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .vstart   (vstart),
    .load     (load),
    .hstart   (hstart),
    .hmirror  (hmirror),
    .vmirror  (vmirror),
    .rom_addr (rom_addr_b),
    .rom_bits (rom_bits_b),
    .gfx      (gfx_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Pixel k (in output order) of a sprite row, straight from the ROM bytes.
  function automatic logic exp_pix(input logic is_b, input int row, input int k, input logic hm);
    int w;
    int idx;
    logic [7:0] byte_v;
    w = is_b ? 32 : 16;
    idx = hm ? (w - 1 - k) : k;
    if (is_b) byte_v = rom_b[row * (w / 8) + idx / 8];
    else      byte_v = rom_a[row * (w / 8) + idx / 8];
    return byte_v[idx % 8];
  endfunction

  task automatic applyStimulus(input int y, input logic hm, input logic vm, input logic early, input int abort_m);
    int g;
    int row_a;
    int row_b;
    logic act_b;
    logic last_a;
    logic last_b;
    logic exp_a;
    logic exp_b;
    row_a  = vm ? (15 - y) : y;
    row_b  = vm ? (7 - y) : y;
    act_b  = (y < 8);
    last_a = (y == 15);
    last_b = (y == 7);
    g = 9 + int'($urandom_range(0, 3));
    @(negedge clk);
    hmirror = hm;
    vmirror = vm;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 1; i <= g; i++) begin
      if (i > 1) @(negedge clk);
      hstart = 1'b0;
      checkOutput($sformatf("gap gfx_a y%0d i%0d", y, i), gfx_a, 0);
      checkOutput($sformatf("gap gfx_b y%0d i%0d", y, i), gfx_b, 0);
      checkOutput($sformatf("gap busy_a y%0d i%0d", y, i), busy_a, 1);
      checkOutput($sformatf("gap busy_b y%0d i%0d", y, i), busy_b, act_b);
      if ((i % 2 == 0) && (i / 2 - 1 < 2))
        checkOutput($sformatf("rom_addr_a y%0d i%0d", y, i), rom_addr_a, row_a * 2 + i / 2 - 1);
      if (act_b && (i % 2 == 0) && (i / 2 - 1 < 4))
        checkOutput($sformatf("rom_addr_b y%0d i%0d", y, i), rom_addr_b, row_b * 4 + i / 2 - 1);
      if ((early && i == 3) || i == g) hstart = 1'b1;
    end
    for (int m = 0; m <= 33; m++) begin
      @(negedge clk);
      hstart = 1'b0;
      if (m == abort_m) begin
        reset = 1'b1;
        #1;
        checkOutput("abort gfx_a", gfx_a, 0);
        checkOutput("abort busy_a", busy_a, 0);
        checkOutput("abort done_a", done_a, 0);
        checkOutput("abort gfx_b", gfx_b, 0);
        checkOutput("abort busy_b", busy_b, 0);
        return;
      end
      exp_a = 1'b0;
      exp_b = 1'b0;
      if (m >= 1 && m <= 16) exp_a = exp_pix(1'b0, row_a, m - 1, hm);
      if (act_b && m >= 1 && m <= 32) exp_b = exp_pix(1'b1, row_b, m - 1, hm);
      checkOutput($sformatf("gfx_a y%0d m%0d", y, m), gfx_a, exp_a);
      checkOutput($sformatf("gfx_b y%0d m%0d", y, m), gfx_b, exp_b);
      checkOutput($sformatf("done_a y%0d m%0d", y, m), done_a, last_a && m == 16);
      checkOutput($sformatf("done_b y%0d m%0d", y, m), done_b, last_b && m == 32);
      checkOutput($sformatf("busy_a y%0d m%0d", y, m), busy_a, !(last_a && m >= 16));
      checkOutput($sformatf("busy_b y%0d m%0d", y, m), busy_b, act_b && !(last_b && m >= 32));
    end
  endtask

  // mode 0: no mirroring, mode 1: both mirrors, otherwise random mirrors and early hstart pulses.
  task automatic run_frame(input int mode, input int abort_line);
    logic hm;
    logic vm;
    logic early;
    @(negedge clk);
    vstart = 1'b1;
    @(negedge clk);
    vstart = 1'b0;
    checkOutput("frame start busy_a", busy_a, 1);
    checkOutput("frame start busy_b", busy_b, 1);
    for (int y = 0; y < 16; y++) begin
      case (mode)
        0: begin hm = 1'b0; vm = 1'b0; early = 1'b0; end
        1: begin hm = 1'b1; vm = 1'b1; early = 1'b0; end
        default: begin
          hm = 1'($urandom_range(0, 1));
          vm = 1'($urandom_range(0, 1));
          early = 1'($urandom_range(0, 1));
        end
      endcase
      applyStimulus(y, hm, vm, early, (y == abort_line) ? 7 : -1);
      if (y == abort_line) begin
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checkOutput("post-abort done_a", done_a, 0);
          checkOutput("post-abort busy_a", busy_a, 0);
          checkOutput("post-abort gfx_a", gfx_a, 0);
        end
        checkOutput("post-abort rom_addr_a", rom_addr_a, 0);
        return;
      end
    end
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset   = 1'b1;
    vstart  = 1'b0;
    load    = 1'b0;
    hstart  = 1'b0;
    hmirror = 1'b0;
    vmirror = 1'b0;
    for (int r = 0; r < 16; r++) begin
      logic [15:0] word;
      word = 16'h8001 ^ 16'(r);
      rom_a[2*r]     = word[7:0];
      rom_a[2*r + 1] = word[15:8];
    end
    for (int a = 0; a < 32; a++) rom_b[a] = 8'($urandom);

    repeat (3) @(negedge clk);
    checkOutput("reset rom_addr_a", rom_addr_a, 0);
    checkOutput("reset gfx_a", gfx_a, 0);
    checkOutput("reset busy_a", busy_a, 0);
    checkOutput("reset done_a", done_a, 0);
    checkOutput("reset busy_b", busy_b, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle busy_a", busy_a, 0);

    run_frame(0, -1);
    for (int a = 0; a < 32; a++) rom_a[a] = 8'($urandom);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(2, 5);
    run_frame(2, -1);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
